led_scan_seq: RTL



---
 rtl/led_scan_pkg.sv | 14 +
 rtl/led_scan_seq_if.sv | 31 +++
 rtl/led_scan_strobe.sv | 31 +++
 rtl/led_scan_seq.sv | 116 +++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED ping-pong scan sequencer:
// state encodings and index limits.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } scan_state_t;

  localparam int SCAN_IDX_W = 3;
  localparam logic [SCAN_IDX_W-1:0] SCAN_MAX = 3'd7;

endpackage

// File: rtl/led_scan_seq_if.sv
// Control/decoder-facing signal bundle of the scan sequencer.
// Master is the control side (buttons/CPU); slave is the sequencer.
interface led_scan_seq_if;
  import led_scan_pkg::*;

  logic                  i_start;
  logic                  i_stop;
  logic [SCAN_IDX_W-1:0] o_index;
  logic                  o_enable;
  logic                  o_dir;
  logic                  o_done;

  modport master (
    output i_start,
    output i_stop,
    input  o_index,
    input  o_enable,
    input  o_dir,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_stop,
    output o_index,
    output o_enable,
    output o_dir,
    output o_done
  );

endinterface

// File: rtl/led_scan_strobe.sv
// Clock divider for the scan: counts 0..CLK_DIV-1 while running and
// flags a one-cycle step on the terminal count.
module led_scan_strobe #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic clear,
  input  logic run,
  output logic step
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // With CLK_DIV=1 the counter is pinned at 0, so every running cycle steps.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign step = run && !clear && (cnt_q == LAST);

endmodule

// File: rtl/led_scan_seq.sv
// Ping-pong 0..7..0 index generator feeding the 3-to-8 LED decoder.
// Define LED_SCAN_LOOP_EN to scan continuously instead of one sweep.
module led_scan_seq
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  led_scan_seq_if.slave bus
);

  scan_state_t           state_q, state_d;
  logic [SCAN_IDX_W-1:0] index_q, index_d;
  logic                  enable_q, enable_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  step;

  led_scan_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (state_q == IDLE),
    .run       (state_q != IDLE),
    .step      (step)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      enable_q <= 1'b0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
    end
  end

  // Stop outranks the step, so a stop on the final step suppresses done.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    enable_d = enable_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          state_d  = UP;
          index_d  = '0;
          enable_d = 1'b1;
          dir_d    = 1'b0;
        end
      end
      UP: begin
        if (bus.i_stop) begin
          state_d  = IDLE;
          index_d  = '0;
          enable_d = 1'b0;
          dir_d    = 1'b0;
        end else if (step) begin
          if (index_q == SCAN_MAX) begin
            state_d = DOWN;
            index_d = SCAN_MAX - 3'd1;
            dir_d   = 1'b1;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end
      DOWN: begin
        if (bus.i_stop) begin
          state_d  = IDLE;
          index_d  = '0;
          enable_d = 1'b0;
          dir_d    = 1'b0;
        end else if (step) begin
          if (index_q != '0) begin
            index_d = index_q - 3'd1;
          end else begin
`ifdef LED_SCAN_LOOP_EN
            state_d = UP;
            index_d = 3'd1;
            dir_d   = 1'b0;
`else
            state_d  = IDLE;
            index_d  = '0;
            enable_d = 1'b0;
            dir_d    = 1'b0;
            done_d   = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d  = IDLE;
        index_d  = '0;
        enable_d = 1'b0;
        dir_d    = 1'b0;
      end
    endcase
  end

  assign bus.o_index  = index_q;
  assign bus.o_enable = enable_q;
  assign bus.o_dir    = dir_q;
  assign bus.o_done   = done_q;

endmodule
